// File: rtl/mem_wb.sv
// MEM/WB pipeline register: stall/flush control plus big-endian load alignment and extension.
// Optional LL/SC link bit is compiled in with `MEM_WB_LLBIT_EN.
module mem_wb (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_ldop,
  input  logic [1:0]  mem_addr_lo,
  input  logic [31:0] mem_rdata,
  input  logic        mem_whilo,
  input  logic [31:0] mem_hi,
  input  logic [31:0] mem_lo,
`ifdef MEM_WB_LLBIT_EN
  input  logic        mem_llbit_we,
  input  logic        mem_llbit_value,
  output logic        llbit_o,
`endif
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        wb_whilo,
  output logic [31:0] wb_hi,
  output logic [31:0] wb_lo,
  output logic        wb_misalign
);

  localparam logic [2:0] LD_LB = 3'd1, LD_LBU = 3'd2, LD_LH = 3'd3, LD_LHU = 3'd4, LD_LW = 3'd5;

  logic [4:0]  wd_q, wd_d;
  logic        wreg_q, wreg_d, whilo_q, whilo_d, mis_q, mis_d;
  logic [31:0] wdata_q, wdata_d, hi_q, hi_d, lo_q, lo_d;
  logic [31:0] ld_data, byte_w;
  logic [15:0] half_v;
  logic        misalign;
  logic        zero_slot, hold;

  // Only the MEM and WB stall bits matter here.
  logic unused_stall;
  assign unused_stall = ^stall[3:0];

  assign zero_slot = rst | flush | (stall[4] & ~stall[5]);
  assign hold      = stall[4] & stall[5];

  // Byte n of a big-endian word sits at bits [31-8n -: 8].
  assign byte_w = mem_rdata >> {~mem_addr_lo, 3'b000};
  assign half_v = mem_addr_lo[1] ? mem_rdata[15:0] : mem_rdata[31:16];

  always_comb begin
    ld_data  = mem_wdata;
    misalign = 1'b0;
    case (mem_ldop)
      LD_LB:  ld_data = {{24{byte_w[7]}}, byte_w[7:0]};
      LD_LBU: ld_data = {24'd0, byte_w[7:0]};
      LD_LH:  begin ld_data = {{16{half_v[15]}}, half_v}; misalign = mem_addr_lo[0]; end
      LD_LHU: begin ld_data = {16'd0, half_v};            misalign = mem_addr_lo[0]; end
      LD_LW:  begin ld_data = mem_rdata;                  misalign = |mem_addr_lo;   end
      default: ld_data = mem_wdata;
    endcase
  end

  always_comb begin
    wd_d = wd_q; wreg_d = wreg_q; wdata_d = wdata_q;
    whilo_d = whilo_q; hi_d = hi_q; lo_d = lo_q; mis_d = mis_q;
    if (zero_slot) begin
      wd_d = '0; wreg_d = 1'b0; wdata_d = '0;
      whilo_d = 1'b0; hi_d = '0; lo_d = '0; mis_d = 1'b0;
    end else if (!hold) begin
      wd_d    = mem_wd;
      wreg_d  = mem_wreg & ~misalign;
      wdata_d = misalign ? 32'd0 : ld_data;
      mis_d   = misalign;
      whilo_d = mem_whilo;
      hi_d    = mem_hi;
      lo_d    = mem_lo;
    end
  end

  always_ff @(posedge clk) begin
    wd_q    <= wd_d;
    wreg_q  <= wreg_d;
    wdata_q <= wdata_d;
    whilo_q <= whilo_d;
    hi_q    <= hi_d;
    lo_q    <= lo_d;
    mis_q   <= mis_d;
  end

  assign wb_wd       = wd_q;
  assign wb_wreg     = wreg_q;
  assign wb_wdata    = wdata_q;
  assign wb_whilo    = whilo_q;
  assign wb_hi       = hi_q;
  assign wb_lo       = lo_q;
  assign wb_misalign = mis_q;

`ifdef MEM_WB_LLBIT_EN
  logic llwe_q, llwe_d, llval_q, llval_d, llbit_q, llbit_d;

  always_comb begin
    llwe_d  = llwe_q;
    llval_d = llval_q;
    if (zero_slot) begin
      llwe_d  = 1'b0;
      llval_d = 1'b0;
    end else if (!hold) begin
      llwe_d  = mem_llbit_we;
      llval_d = mem_llbit_value;
    end
    llbit_d = llbit_q;
    if (rst || flush)  llbit_d = 1'b0;
    else if (llwe_q)   llbit_d = llval_q;
  end

  always_ff @(posedge clk) begin
    llwe_q  <= llwe_d;
    llval_q <= llval_d;
    llbit_q <= llbit_d;
  end

  // Forward the pending WB update so an SC in MEM sees it immediately.
  assign llbit_o = llwe_q ? llval_q : llbit_q;
`endif

endmodule

// File: doc/mem_wb.md
# mem_wb

Pipeline register and write-back stage between the MEM stage and the general-purpose register file. It captures MEM results on each clock, applies stall/flush control, and aligns and sign/zero-extends load data (big-endian byte lanes). It then drives the register-file write port (`we`/`waddr`/`wdata`) and the HI/LO write port. It optionally holds the LL/SC link bit.

## Interface
Parameters: none. Widths come from the shared defines: RegBus = 32, RegAddrBus = 5.

Clock and reset:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high

Control:
- stall  in  6  pipeline stall vector; bit 4 = MEM, bit 5 = WB
- flush  in  1  exception flush; squashes the WB slot

MEM-side inputs:
- mem_wd  in  5  destination register
- mem_wreg  in  1  register write request
- mem_wdata  in  32  ALU/move result (used when mem_ldop = 0)
- mem_ldop  in  3  load type: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW; 6–7 reserved, treated as 0
- mem_addr_lo  in  2  load byte address bits [1:0]
- mem_rdata  in  32  raw big-endian word from data memory
- mem_whilo  in  1  HI/LO write request
- mem_hi, mem_lo  in  32 each  HI/LO values

Write-back outputs (to the register file and HI/LO):
- wb_wd  out  5  register file waddr
- wb_wreg  out  1  register file we
- wb_wdata  out  32  register file wdata
- wb_whilo  out  1  HI/LO write enable
- wb_hi, wb_lo  out  32 each  HI/LO data
- wb_misalign  out  1  registered misaligned-load flag

## Operation
Capture priority at each posedge, highest first:
1. rst: every output = 0.
2. flush: every output = 0.
3. stall[4]=1 and stall[5]=0: insert a bubble; every output = 0.
4. stall[4]=1 and stall[5]=1: hold; outputs keep their values.
5. stall[4]=0: capture; wb_wd ← mem_wd, wb_whilo/hi/lo ← inputs, data per the load rules below.

Load alignment (byte 0 = bits [31:24]):
- LB/LBU: addr_lo selects byte n = bits [31-8n : 24-8n]. LB sign-extends, LBU zero-extends.
- LH/LHU: addr_lo 0 → [31:16], 2 → [15:0]. LH sign-extends, LHU zero-extends.
- LW: the whole word.
- ldop 0: wb_wdata ← mem_wdata.

Misalignment:
- Condition: LH/LHU with addr_lo[0]=1, or LW with addr_lo≠0.
- Effect: wb_wreg ← 0, wb_wdata ← 0, wb_misalign ← 1.
- Otherwise wb_wreg ← mem_wreg and wb_misalign ← 0.

## Timing
- Latency is exactly 1 cycle, MEM capture to wb_* valid. The register file writes on the following posedge.
- The register file bypasses same-cycle reads, so wb_* values are visible to the ID stage in the cycle they are presented.
- After rst is deasserted, the first capture occurs on the first posedge with stall[4]=0.
- A flush during a hold still zeroes outputs; the held instruction is lost by design.
- A bubble always produces wb_wreg=0 and wb_whilo=0, so there is no duplicate write.

## Configuration
Macro `MEM_WB_LLBIT_EN` compiles the LL/SC link bit in or out.

Defined:
- Extra ports:
  - mem_llbit_we  in  1
  - mem_llbit_value  in  1
  - llbit_o  out  1
- Pipeline fields: wb_llbit_we and wb_llbit_value are registered with the same priority and hold/bubble rules as the other outputs.
- Register `llbit` update: rst or flush → 0; else if wb_llbit_we → wb_llbit_value.
- llbit_o = wb_llbit_we ? wb_llbit_value : llbit (forwarded for SC in MEM).

Undefined: the ports and the `llbit` register are absent.

## Test plan
- Reset: hold rst for 2 cycles with nonzero inputs → every output is 0. Release with wd=3, wreg=1, wdata=0x12345678 → next cycle wb_wd=3, wb_wreg=1, wb_wdata=0x12345678.
- Loads: rdata=0x80FF7F01.
  - LB with addr_lo=0 → 0xFFFFFF80; LBU with addr_lo=1 → 0x000000FF.
  - LH with addr_lo=2 → 0x00007F01; LH with addr_lo=0 → 0xFFFF80FF.
  - LW → 0x80FF7F01.
- Misaligned LW with addr_lo=1 and wreg=1 → wb_wreg=0, wb_wdata=0, wb_misalign=1.
- Stall: capture wdata=0xA, then apply stall=6'b110000 for 2 cycles → outputs stay at 0xA. Then stall=6'b010000 → outputs are 0 (bubble).
- Flush with wreg=1, whilo=1 → next cycle wb_wreg=0, wb_whilo=0, wb_wdata=0.
- LLbit (macro defined): LL with llbit_we=1, value=1 → llbit_o=1 in the WB cycle and stays 1. Flush → llbit_o=0 one cycle later.
